// File: rtl/rt_get_arbiter.sv
// Round-robin arbiter sharing one timed resource, with response budgets.
// Ports: clk, rst_n, req, ctrl_ok, clr_budget, response -> grant, _rt_get, busy, denied, error.
module rt_get_arbiter #(
  parameter int N_REQ   = 2,
  parameter int BUDGET  = 3,
  parameter int TIMEOUT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ctrl_ok,
  input  logic             clr_budget,
  input  logic             response,
  output logic [N_REQ-1:0] grant,
  output logic             _rt_get,
  output logic             busy,
  output logic             denied,
  output logic             error
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BUDGET + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0]    CMAX  = CW'(BUDGET);
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);
  localparam logic [LW-1:0]    LRST  = LW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt [N_REQ];
  logic [TW-1:0]     timer;
  logic [LW-1:0]     last;
  logic [LW-1:0]     owner;
  logic [N_REQ-1:0]  exhausted;
  logic [N_REQ-1:0]  elig;
  logic [LW-1:0]     pick;
  logic [LW-1:0]     hi;
  logic [LW-1:0]     lo;
  logic              hi_ok;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      exhausted[k] = (cnt[k] == CMAX);
    end
  end

  assign elig = req & ~exhausted;

  // Lowest eligible index above last wins; otherwise wrap to the
  // lowest eligible index overall.
  always_comb begin
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        lo = LW'(k);
        if (k > int'(last)) begin
          hi    = LW'(k);
          hi_ok = 1'b1;
        end
      end
    end
    pick = hi_ok ? hi : lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      _rt_get <= 1'b0;
      busy    <= 1'b0;
      denied  <= 1'b0;
      error   <= 1'b0;
      timer   <= '0;
      last    <= LRST;
      owner   <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      denied <= 1'b0;
      unique case (state)
        IDLE: begin
          denied <= |(req & exhausted);
          if (response) begin
            error <= 1'b1;
          end
          if (ctrl_ok && |elig) begin
            grant   <= ONE << pick;
            owner   <= pick;
            _rt_get <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          _rt_get <= 1'b0;
          timer   <= '0;
          state   <= WAIT;
          if (response) begin
            error <= 1'b1;
          end
        end
        WAIT: begin
          if (response) begin
            for (int k = 0; k < N_REQ; k++) begin
              if (LW'(k) == owner && cnt[k] != CMAX) begin
                cnt[k] <= cnt[k] + 1'b1;
              end
            end
            last  <= owner;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TLAST) begin
            error <= 1'b1;
            last  <= owner;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Clearing takes priority over a same-edge increment.
      if (clr_budget) begin
        for (int k = 0; k < N_REQ; k++) begin
          cnt[k] <= '0;
        end
      end
    end
  end

endmodule
